// File: rtl/cvxif_instr_pkg.sv
// Shared CV-X-IF coprocessor types: the instruction match table entry,
// the decoded operation and the control part of an issue queue slot.
package cvxif_instr_pkg;

    typedef enum logic [3:0] {
        ILLEGAL = 4'h0,
        VADD    = 4'h1,
        VSUB    = 4'h2,
        VAND    = 4'h3,
        VOR     = 4'h4,
        VXOR    = 4'h5,
        VMUL    = 4'h6,
        VMAC    = 4'h7
    } custom_vec_op_e;

    typedef struct packed {
        logic accept;
        logic writeback;
    } x_issue_resp_t;

    typedef struct packed {
        logic [31:0]    instr;
        logic [31:0]    mask;
        x_issue_resp_t  resp;
        custom_vec_op_e op;
    } copro_issue_resp_t;

    // Control half of a queue slot; ID and operands live in separate
    // arrays so their widths can follow the top-level parameters.
    typedef struct packed {
        logic           valid;
        logic           committed;
        logic           killed;
        logic           writeback;
        custom_vec_op_e op;
    } copro_queue_entry_t;

    localparam copro_issue_resp_t CoproInstrNone = '0;

    // An entry matches when the masked instruction equals its pattern.
    function automatic logic instr_matches(input copro_issue_resp_t entry,
                                           input logic [31:0]       instr);
        return (instr & entry.mask) == entry.instr;
    endfunction

endpackage

// File: rtl/copro_match_table.sv
// Combinational priority matcher over the offload instruction table.
// Lowest matching index wins; multi_hit_o flags overlapping entries.
module copro_match_table
    import cvxif_instr_pkg::*;
#(
    parameter int unsigned       NbInstr                  = 1,
    parameter copro_issue_resp_t CoproInstr [NbInstr]     = '{default: CoproInstrNone},
    parameter bit                EnableCustomVec          = 1'b0
) (
    input  logic           valid_i,
    input  logic [31:0]    instr_i,
    output logic           hit_o,
    output logic           multi_hit_o,
    output x_issue_resp_t  resp_o,
    output custom_vec_op_e op_o
);

    // Scan from the top index down so the lowest matching index is the last writer.
    always_comb begin
        hit_o       = 1'b0;
        multi_hit_o = 1'b0;
        resp_o      = '0;
        op_o        = ILLEGAL;
        if (EnableCustomVec && valid_i) begin
            for (int i = int'(NbInstr) - 1; i >= 0; i--) begin
                if (instr_matches(CoproInstr[i], instr_i)) begin
                    if (hit_o) begin
                        multi_hit_o = 1'b1;
                    end
                    hit_o  = 1'b1;
                    resp_o = CoproInstr[i].resp;
                    op_o   = CoproInstr[i].op;
                end
            end
        end
    end

endmodule

// File: rtl/copro_issue_queue.sv
// Coprocessor issue queue: decodes offloaded instructions against the
// match table, holds accepted ones in an ID-tagged circular buffer until
// the core commits or kills them, and releases committed ones in order.
module copro_issue_queue
    import cvxif_instr_pkg::*;
#(
    parameter int unsigned       NbInstr                  = 1,
    parameter copro_issue_resp_t CoproInstr [NbInstr]     = '{default: CoproInstrNone},
    parameter bit                EnableCustomVec          = 1'b0,
    parameter int unsigned       Depth                    = 4,
    parameter int unsigned       IdWidth                  = 3,
    parameter int unsigned       XLen                     = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       issue_valid_i,
    output logic                       issue_ready_o,
    input  logic [31:0]                issue_instr_i,
    input  logic [IdWidth-1:0]         issue_id_i,
    input  logic [XLen-1:0]            issue_rs0_i,
    input  logic [XLen-1:0]            issue_rs1_i,
    output logic                       issue_accept_o,
    output logic                       issue_writeback_o,
    input  logic                       commit_valid_i,
    input  logic [IdWidth-1:0]         commit_id_i,
    input  logic                       commit_kill_i,
    output logic                       exe_valid_o,
    input  logic                       exe_ready_i,
    output custom_vec_op_e             exe_op_o,
    output logic [IdWidth-1:0]         exe_id_o,
    output logic [XLen-1:0]            exe_rs0_o,
    output logic [XLen-1:0]            exe_rs1_o,
    output logic                       exe_writeback_o,
    output logic [$clog2(Depth):0]     occupancy_o,
    output logic                       multi_match_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth) + 1;

    copro_queue_entry_t ctrl_q [Depth];
    logic [IdWidth-1:0] id_q   [Depth];
    logic [XLen-1:0]    rs0_q  [Depth];
    logic [XLen-1:0]    rs1_q  [Depth];
    logic [PtrW-1:0]    head_q;
    logic [PtrW-1:0]    tail_q;
    logic [CntW-1:0]    count_q;
    logic               multi_match_q;

    logic               hit;
    logic               multi_hit;
    x_issue_resp_t      resp_hit;
    custom_vec_op_e     op_hit;
    logic               full;
    logic               id_held;
    logic               push;
    logic               pop;
    logic               head_drop;
    logic               commit_on_push;
    copro_queue_entry_t head_ctrl;

    copro_match_table #(
        .NbInstr         (NbInstr),
        .CoproInstr      (CoproInstr),
        .EnableCustomVec (EnableCustomVec)
    ) u_match_table (
        .valid_i     (issue_valid_i),
        .instr_i     (issue_instr_i),
        .hit_o       (hit),
        .multi_hit_o (multi_hit),
        .resp_o      (resp_hit),
        .op_o        (op_hit)
    );

    // An ID may only be in flight once; killed entries still hold their ID until popped.
    always_comb begin
        id_held = 1'b0;
        for (int i = 0; i < int'(Depth); i++) begin
            if (ctrl_q[i].valid && (id_q[i] == issue_id_i)) begin
                id_held = 1'b1;
            end
        end
    end

    assign full              = (count_q == CntW'(Depth));
    assign issue_ready_o     = !full;
    assign issue_accept_o    = issue_ready_o && hit && resp_hit.accept && !id_held;
    assign issue_writeback_o = issue_accept_o && resp_hit.writeback;
    assign push              = issue_accept_o;
    assign commit_on_push    = commit_valid_i && (commit_id_i == issue_id_i);

    assign head_ctrl       = ctrl_q[head_q];
    assign exe_valid_o     = head_ctrl.valid && head_ctrl.committed && !head_ctrl.killed;
    assign head_drop       = head_ctrl.valid && head_ctrl.committed && head_ctrl.killed;
    assign pop             = (exe_valid_o && exe_ready_i) || head_drop;
    assign exe_op_o        = exe_valid_o ? head_ctrl.op : ILLEGAL;
    assign exe_id_o        = exe_valid_o ? id_q[head_q] : '0;
    assign exe_rs0_o       = exe_valid_o ? rs0_q[head_q] : '0;
    assign exe_rs1_o       = exe_valid_o ? rs1_q[head_q] : '0;
    assign exe_writeback_o = exe_valid_o && head_ctrl.writeback;
    assign occupancy_o     = count_q;
    assign multi_match_o   = multi_match_q;

    // Slot control state, pointers, occupancy and the sticky multi-match flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) begin
                ctrl_q[i] <= '0;
            end
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            multi_match_q <= 1'b0;
        end else begin
            for (int i = 0; i < int'(Depth); i++) begin
                if (push && (tail_q == PtrW'(i))) begin
                    ctrl_q[i].valid     <= 1'b1;
                    ctrl_q[i].committed <= commit_on_push;
                    ctrl_q[i].killed    <= commit_on_push && commit_kill_i;
                    ctrl_q[i].writeback <= resp_hit.writeback;
                    ctrl_q[i].op        <= op_hit;
                end else if (pop && (head_q == PtrW'(i))) begin
                    ctrl_q[i] <= '0;
                end else if (commit_valid_i && ctrl_q[i].valid && (id_q[i] == commit_id_i)) begin
                    ctrl_q[i].committed <= 1'b1;
                    if (commit_kill_i) begin
                        ctrl_q[i].killed <= 1'b1;
                    end
                end
            end
            if (push) begin
                tail_q <= tail_q + PtrW'(1);
            end
            if (pop) begin
                head_q <= head_q + PtrW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
            if (multi_hit) begin
                multi_match_q <= 1'b1;
            end
        end
    end

    // Slot payload; only meaningful while the matching control slot is valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            id_q[tail_q]  <= issue_id_i;
            rs0_q[tail_q] <= issue_rs0_i;
            rs1_q[tail_q] <= issue_rs1_i;
        end
    end

`ifndef SYNTHESIS
    // Overlapping table entries usually mean a mis-specified table; report each occurrence.
    always_ff @(posedge clk_i) begin
        if (rst_ni && multi_hit) begin
            $warning("copro_issue_queue: instruction %h hit several table entries", issue_instr_i);
        end
    end
`endif

endmodule

// File: tb/tb_copro_issue_queue.sv
// Bench for copro_issue_queue: directed vectors, hand-written corner
// sequences and random traffic checked against a queue-based model.
module tb_copro_issue_queue;
    import cvxif_instr_pkg::*;

    localparam logic [31:0] I_ADD = 32'h0000000B;  // hits entries 0 and 2
    localparam logic [31:0] I_SUB = 32'h0000100B;  // entry 1 only
    localparam logic [31:0] I_XOR = 32'h0200000B;  // entry 2 only
    localparam logic [31:0] I_REJ = 32'h0000200B;  // entry 3 only, not accepted
    localparam logic [31:0] I_NOM = 32'h00000033;  // no entry

    localparam copro_issue_resp_t TBL [4] = '{
        '{instr: 32'h0000000B, mask: 32'hFE00707F, resp: '{accept: 1'b1, writeback: 1'b1}, op: VADD},
        '{instr: 32'h0000100B, mask: 32'hFE00707F, resp: '{accept: 1'b1, writeback: 1'b0}, op: VSUB},
        '{instr: 32'h0000000B, mask: 32'h0000707F, resp: '{accept: 1'b1, writeback: 1'b1}, op: VXOR},
        '{instr: 32'h0000200B, mask: 32'h0000707F, resp: '{accept: 1'b0, writeback: 1'b1}, op: VMUL}
    };

    logic        clk;
    logic        rst_ni;
    logic        issue_valid;
    logic [31:0] issue_instr;
    logic [2:0]  issue_id;
    logic [31:0] issue_rs0, issue_rs1;
    logic        commit_valid;
    logic [2:0]  commit_id;
    logic        commit_kill;
    logic        exe_ready;

    logic           issue_ready, issue_accept, issue_wb;
    logic           exe_valid, exe_wb, multi_match;
    custom_vec_op_e exe_op;
    logic [2:0]     exe_id;
    logic [31:0]    exe_rs0, exe_rs1;
    logic [2:0]     occupancy;

    logic           off_ready, off_accept, off_wb, off_exe_valid, off_exe_wb, off_multi;
    custom_vec_op_e off_exe_op;
    logic [2:0]     off_exe_id;
    logic [31:0]    off_exe_rs0, off_exe_rs1;
    logic [2:0]     off_occ;

    copro_issue_queue #(
        .NbInstr(4), .CoproInstr(TBL), .EnableCustomVec(1'b1),
        .Depth(4), .IdWidth(3), .XLen(32)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
        .issue_instr_i(issue_instr), .issue_id_i(issue_id),
        .issue_rs0_i(issue_rs0), .issue_rs1_i(issue_rs1),
        .issue_accept_o(issue_accept), .issue_writeback_o(issue_wb),
        .commit_valid_i(commit_valid), .commit_id_i(commit_id), .commit_kill_i(commit_kill),
        .exe_valid_o(exe_valid), .exe_ready_i(exe_ready), .exe_op_o(exe_op),
        .exe_id_o(exe_id), .exe_rs0_o(exe_rs0), .exe_rs1_o(exe_rs1),
        .exe_writeback_o(exe_wb), .occupancy_o(occupancy), .multi_match_o(multi_match)
    );

    copro_issue_queue #(
        .NbInstr(4), .CoproInstr(TBL), .EnableCustomVec(1'b0),
        .Depth(4), .IdWidth(3), .XLen(32)
    ) dut_off (
        .clk_i(clk), .rst_ni(rst_ni),
        .issue_valid_i(issue_valid), .issue_ready_o(off_ready),
        .issue_instr_i(issue_instr), .issue_id_i(issue_id),
        .issue_rs0_i(issue_rs0), .issue_rs1_i(issue_rs1),
        .issue_accept_o(off_accept), .issue_writeback_o(off_wb),
        .commit_valid_i(commit_valid), .commit_id_i(commit_id), .commit_kill_i(commit_kill),
        .exe_valid_o(off_exe_valid), .exe_ready_i(exe_ready), .exe_op_o(off_exe_op),
        .exe_id_o(off_exe_id), .exe_rs0_o(off_exe_rs0), .exe_rs1_o(off_exe_rs1),
        .exe_writeback_o(off_exe_wb), .occupancy_o(off_occ), .multi_match_o(off_multi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [2:0]     id;
        custom_vec_op_e op;
        logic [31:0]    rs0, rs1;
        bit             wb, committed, killed;
    } mentry_t;

    mentry_t        mq[$];
    bit             m_multi;
    bit             m_push, m_pop, m_wb;
    int             m_nh;
    custom_vec_op_e m_op;

    // First table entry whose masked bits equal its pattern decides; count all hits.
    function automatic void decode(input logic [31:0] instr, output bit hit, output custom_vec_op_e op,
                                   output bit acc, output bit wb, output int nh);
        hit = 0; op = ILLEGAL; acc = 0; wb = 0; nh = 0;
        for (int k = 0; k < 4; k++) begin
            if ((instr & TBL[k].mask) == TBL[k].instr) begin
                if (nh == 0) begin
                    hit = 1; op = TBL[k].op; acc = TBL[k].resp.accept; wb = TBL[k].resp.writeback;
                end
                nh++;
            end
        end
    endfunction

    task automatic model_check();
        bit full, held, hit, acc, wb, hv;
        int nh;
        custom_vec_op_e op;
        full = (mq.size() == 4);
        decode(issue_instr, hit, op, acc, wb, nh);
        held = 0;
        foreach (mq[k]) if (mq[k].id == issue_id) held = 1;
        m_push = issue_valid && !full && hit && acc && !held;
        m_wb = wb; m_op = op; m_nh = issue_valid ? nh : 0;
        hv = (mq.size() > 0) && mq[0].committed && !mq[0].killed;
        m_pop = (hv && exe_ready) || ((mq.size() > 0) && mq[0].committed && mq[0].killed);
        check("ready", issue_ready, !full);
        check("accept", issue_accept, m_push);
        check("issue_wb", issue_wb, m_push && wb);
        check("exe_valid", exe_valid, hv);
        check("exe_op", exe_op, hv ? mq[0].op : ILLEGAL);
        check("exe_id", exe_id, hv ? mq[0].id : 3'd0);
        check("exe_rs0", exe_rs0, hv ? mq[0].rs0 : 32'd0);
        check("exe_rs1", exe_rs1, hv ? mq[0].rs1 : 32'd0);
        check("exe_wb", exe_wb, hv && mq[0].wb);
        check("occupancy", occupancy, mq.size());
        check("multi_match", multi_match, m_multi);
        check("off_accept", off_accept, 1'b0);
        check("off_occ", off_occ, 3'd0);
    endtask

    task automatic model_update();
        mentry_t e;
        if (m_nh >= 2) m_multi = 1;
        if (commit_valid)
            foreach (mq[k]) if (mq[k].id == commit_id) begin
                mq[k].committed = 1;
                if (commit_kill) mq[k].killed = 1;
            end
        if (m_pop) void'(mq.pop_front());
        if (m_push) begin
            e.id = issue_id; e.op = m_op; e.rs0 = issue_rs0; e.rs1 = issue_rs1; e.wb = m_wb;
            e.committed = commit_valid && (commit_id == issue_id);
            e.killed = e.committed && commit_kill;
            mq.push_back(e);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_check();
        @(posedge clk);
        if (rst_ni) model_update();
        #1;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        issue_valid = 0; issue_instr = I_NOM; issue_id = 0; issue_rs0 = 0; issue_rs1 = 0;
        commit_valid = 0; commit_id = 0; commit_kill = 0; exe_ready = 0;
    endtask

    task automatic issue(input logic [31:0] instr, input logic [2:0] id);
        issue_valid = 1; issue_instr = instr; issue_id = id;
        issue_rs0 = $urandom; issue_rs1 = $urandom;
    endtask

    task automatic drive_random();
        int sel;
        idle();
        sel = $urandom_range(0, 3);
        issue(sel == 0 ? I_SUB : sel == 1 ? I_XOR : sel == 2 ? I_REJ : I_NOM, 3'($urandom_range(0, 7)));
        issue_valid = ($urandom_range(0, 3) != 0);
        commit_valid = $urandom_range(0, 1);
        if (mq.size() > 0 && $urandom_range(0, 3) != 0)
            commit_id = mq[$urandom_range(0, mq.size() - 1)].id;
        else
            commit_id = 3'($urandom_range(0, 7));
        commit_kill = ($urandom_range(0, 3) == 0);
        exe_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic drain();
        for (int n = 0; n < 60 && mq.size() > 0; n++) begin
            idle();
            exe_ready = 1;
            if (!mq[0].committed) begin
                commit_valid = 1; commit_id = mq[0].id;
            end
            tick();
        end
        idle();
        #1 check("drain_empty", occupancy, 3'd0);
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  id;
        bit          exp_acc;
        bit          exp_wb;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{I_SUB, 3'd1, 1'b1, 1'b0};
        vecs[1] = '{I_XOR, 3'd2, 1'b1, 1'b1};
        vecs[2] = '{I_REJ, 3'd3, 1'b0, 1'b0};
        vecs[3] = '{I_NOM, 3'd4, 1'b0, 1'b0};
        vecs[4] = '{I_XOR, 3'd5, 1'b1, 1'b1};

        m_multi = 0;
        idle();
        rst_ni = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_occ", occupancy, 3'd0);
        check("rst_exe_valid", exe_valid, 1'b0);
        check("rst_multi", multi_match, 1'b0);
        rst_ni = 1;
        #1;
        check("rst_ready", issue_ready, 1'b1);
        check("rst_accept", issue_accept, 1'b0);
        check("rst_exe_id", exe_id, 3'd0);
        tick();

        // Table vectors: each request is killed on issue so it drains by itself.
        for (int v = 0; v < 5; v++) begin
            idle();
            issue(vecs[v].instr, vecs[v].id);
            commit_valid = 1; commit_id = vecs[v].id; commit_kill = 1;
            #1;
            check("vec_accept", issue_accept, vecs[v].exp_acc);
            check("vec_wb", issue_wb, vecs[v].exp_wb);
            tick();
        end
        idle(); tick(); tick();
        #1 check("vec_occ", occupancy, 3'd0);

        // Minimum latency: issue and commit together, execute next cycle.
        idle(); issue(I_SUB, 3'd1); issue_rs0 = 32'h1111; issue_rs1 = 32'h2222;
        commit_valid = 1; commit_id = 3'd1; exe_ready = 1;
        #1 check("lat_accept", issue_accept, 1'b1);
        tick();
        idle(); exe_ready = 1;
        #1;
        check("lat_exe_valid", exe_valid, 1'b1);
        check("lat_exe_id", exe_id, 3'd1);
        check("lat_exe_rs0", exe_rs0, 32'h1111);
        check("lat_exe_op", exe_op, VSUB);
        tick();
        idle();
        #1 check("lat_occ", occupancy, 3'd0);
        tick();

        // Fill to full, reject a fifth, then free one slot.
        for (int i = 0; i < 4; i++) begin
            idle(); issue(I_XOR, 3'(i)); tick();
        end
        idle();
        #1;
        check("full_occ", occupancy, 3'd4);
        check("full_ready", issue_ready, 1'b0);
        issue(I_XOR, 3'd4);
        #1 check("full_accept", issue_accept, 1'b0);
        tick();
        idle(); commit_valid = 1; commit_id = 3'd0; exe_ready = 1;
        #1 check("full_occ_hold", occupancy, 3'd4);
        tick();
        idle(); exe_ready = 1;
        #1;
        check("full_exe_id", exe_id, 3'd0);
        check("full_ready_popcycle", issue_ready, 1'b0);
        tick();
        #1;
        check("full_ready_after", issue_ready, 1'b1);
        check("full_occ_after", occupancy, 3'd3);
        drain();

        // Duplicate outstanding ID is refused.
        idle(); issue(I_SUB, 3'd2); tick();
        idle(); issue(I_SUB, 3'd2);
        #1 check("dup_accept", issue_accept, 1'b0);
        tick();
        idle(); commit_valid = 1; commit_id = 3'd2; commit_kill = 1; tick();
        drain();

        // Kill/commit pairs; twenty pushes wrap the pointers several times.
        for (int p = 0; p < 10; p++) begin
            logic [2:0] a, b;
            a = 3'(2 * p); b = 3'(2 * p + 1);
            idle(); exe_ready = 1; issue(I_SUB, a); tick();
            idle(); exe_ready = 1; issue(I_XOR, b);
            commit_valid = 1; commit_id = a; commit_kill = 1; tick();
            idle(); exe_ready = 1; commit_valid = 1; commit_id = b;
            #1 check("pair_kill_hidden", exe_valid, 1'b0);
            tick();
            idle(); exe_ready = 1;
            #1;
            check("pair_exe_valid", exe_valid, 1'b1);
            check("pair_exe_id", exe_id, b);
            tick();
        end
        drain();

        // Random traffic against the model.
        repeat (400) begin
            drive_random();
            tick();
        end
        drain();

        // Overlapping entries 0 and 2: entry 0 wins, sticky flag rises.
        idle();
        #1 check("multi_before", multi_match, 1'b0);
        issue(I_ADD, 3'd5); commit_valid = 1; commit_id = 3'd5; exe_ready = 1;
        #1;
        check("multi_accept", issue_accept, 1'b1);
        check("multi_wb", issue_wb, 1'b1);
        tick();
        idle(); exe_ready = 1;
        #1;
        check("multi_exe_op", exe_op, VADD);
        check("multi_flag", multi_match, 1'b1);
        tick();
        repeat (30) begin
            drive_random();
            tick();
        end
        drain();
        #1 check("multi_sticky", multi_match, 1'b1);

        // Asynchronous reset with three entries in flight.
        for (int i = 0; i < 3; i++) begin
            idle(); issue(I_SUB, 3'(i)); tick();
        end
        idle(); commit_valid = 1; commit_id = 3'd0; tick();
        idle();
        #1;
        check("prerst_occ", occupancy, 3'd3);
        check("prerst_exe_valid", exe_valid, 1'b1);
        #1 rst_ni = 0;
        #1;
        check("arst_occ", occupancy, 3'd0);
        check("arst_exe_valid", exe_valid, 1'b0);
        check("arst_multi", multi_match, 1'b0);
        check("arst_ready", issue_ready, 1'b1);
        mq.delete();
        m_multi = 0;
        tick();
        rst_ni = 1;
        idle(); issue(I_XOR, 3'd6); commit_valid = 1; commit_id = 3'd6; exe_ready = 1;
        tick();
        idle(); exe_ready = 1;
        #1 check("postrst_exe_id", exe_id, 3'd6);
        tick();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
